// File: rtl/control_if.sv
// Control-unit bus: opcode/zero in, datapath strobes and debug phase out.
// master is the sequencer, slave is the datapath side.
interface control_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       load_ac;
  logic       inc_pc;
  logic       load_pc;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, load_ac,
    output inc_pc, load_pc, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, load_ac,
    input  inc_pc, load_pc, halt, phase
  );
endinterface

// File: rtl/control.sv
// Eight-phase instruction sequencer for a tiny accumulator CPU.
// Strobes are combinational decodes of phase, opcode, zero and halted.
module control (
  input  logic       clk,
  input  logic       rst,
  control_if.master  bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  state_t state, state_n;
  logic   halted, halted_n;
  logic   aluop;
  logic   is_hlt;

  assign is_hlt = (bus.opcode == HLT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      halted <= halted_n;
    end
  end

  // HLT parks the sequencer on OP_ADDR; the flag then masks all strobes
  always_comb begin
    state_n  = state;
    halted_n = halted;
    if (!halted) begin
      if (state == OP_ADDR && is_hlt) begin
        halted_n = 1'b1;
      end else begin
        state_n = state_t'(state + 3'd1);
      end
    end
  end

  always_comb begin
    aluop = 1'b0;
    unique case (bus.opcode)
      ADD, AND, XOR, LDA: aluop = 1'b1;
      default:            aluop = 1'b0;
    endcase
  end

  always_comb begin
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.load_ir = 1'b0;
    bus.load_ac = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.load_pc = 1'b0;
    bus.halt    = 1'b0;
    bus.phase   = state;
    if (halted) begin
      bus.halt = 1'b1;
    end else begin
      unique case (state)
        INST_ADDR: ;
        INST_FETCH: bus.mem_rd = 1'b1;
        INST_LOAD, IDLE: begin
          bus.mem_rd  = 1'b1;
          bus.load_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
        end
        OP_FETCH: bus.mem_rd = aluop;
        ALU_OP: begin
          bus.mem_rd  = aluop;
          bus.load_ac = aluop;
          bus.inc_pc  = (bus.opcode == SKZ) && bus.zero;
          bus.load_pc = (bus.opcode == JMP);
        end
        STORE: begin
          bus.mem_rd  = aluop;
          bus.load_ac = aluop;
          bus.inc_pc  = (bus.opcode == JMP);
          bus.load_pc = (bus.opcode == JMP);
          bus.mem_wr  = (bus.opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the control sequencer.
// Strobe vectors are {rd,wr,ir,ac,inc,ld,halt}.
module tb_control;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  control_if bus ();

  control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_ac,
                bus.inc_pc, bus.load_pc, bus.halt};

  // phases 0..4 for any non-HLT opcode
  logic [6:0] head [5] = '{7'b0000000, 7'b1000000, 7'b1010000,
                           7'b1010000, 7'b0000100};

  task automatic chk(input string tag, input logic [6:0] got,
                     input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_phase", {4'd0, bus.phase}, 7'd0);
    chk("rst_ctl", ctl, 7'd0);
  endtask

  task automatic run_instr(input string tag, input logic [2:0] op,
                           input logic z, input logic [6:0] t5,
                           input logic [6:0] t6, input logic [6:0] t7);
    logic [6:0] e;
    bus.opcode = op;
    bus.zero   = z;
    #1;
    for (int p = 0; p < 8; p++) begin
      if (p < 5) e = head[p];
      else if (p == 5) e = t5;
      else if (p == 6) e = t6;
      else e = t7;
      chk($sformatf("%s_ph%0d", tag, p), {4'd0, bus.phase}, 7'(p));
      chk($sformatf("%s_ctl%0d", tag, p), ctl, e);
      chk($sformatf("%s_rdwr%0d", tag, p),
          {6'd0, bus.mem_rd & bus.mem_wr}, 7'd0);
      step();
    end
    chk($sformatf("%s_wrap", tag), {4'd0, bus.phase}, 7'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.opcode = 3'd2;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr("add", 3'd2, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000);
    run_instr("sto", 3'd6, 1'b0, 7'b0000000, 7'b0000000, 7'b0100000);
    run_instr("jmp", 3'd7, 1'b0, 7'b0000000, 7'b0000010, 7'b0000110);
    run_instr("skz1", 3'd1, 1'b1, 7'b0000000, 7'b0000100, 7'b0000000);
    run_instr("skz0", 3'd1, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000);
    run_instr("xor", 3'd4, 1'b1, 7'b1000000, 7'b1001000, 7'b1001000);

    // HLT: strobes on first OP_ADDR cycle, then parked
    bus.opcode = 3'd0;
    bus.zero = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("hlt_ctl%0d", p), ctl, head[p]);
      step();
    end
    chk("hlt_ph4", {4'd0, bus.phase}, 7'd4);
    chk("hlt_ctl4", ctl, 7'b0000101);
    step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("hold_ph%0d", i), {4'd0, bus.phase}, 7'd4);
      chk($sformatf("hold_ctl%0d", i), ctl, 7'b0000001);
      bus.opcode = 3'(i);
      bus.zero = i[0];
      step();
    end
    do_reset();
    run_instr("post_hlt", 3'd3, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000);

    // reset mid-instruction at ALU_OP
    bus.opcode = 3'd2;
    repeat (6) step();
    chk("mid_ph6", {4'd0, bus.phase}, 7'd6);
    chk("mid_ctl6", ctl, 7'b1001000);
    do_reset();
    run_instr("after_mid", 3'd2, 1'b0, 7'b1000000, 7'b1001000, 7'b1001000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
